// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states,
// read-response owner tags and the default debug starvation threshold.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int DEF_MAX_WAIT = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU MEM-stage, debug-port and SRAM signals around the arbiter.
// slave = arbiter view, master = surrounding requesters and SRAM.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_aging.sv
// Debug starvation counter: counts consecutive lost debug cycles, saturating
// at MAX_WAIT; hit_o tells the arbiter to hand the next slot to debug.
module dmem_arb_aging #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_req_i,
  input  logic dbg_gnt_i,
  output logic hit_o
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_req_i || dbg_gnt_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  assign hit_o = (wait_cnt_q == CNT_MAX);
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port SRAM arbiter between CPU MEM stage and debug/loader port.
// Define DMEM_ARB_AGING_EN to bound debug starvation at MAX_WAIT lost cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  if (MAX_WAIT < 1) begin : g_cfg_check
    $error("dmem_arbiter: MAX_WAIT must be at least 1");
  end

  state_e            state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  owner_e            rd_own_q, rd_own_d;
  logic              aging_hit;
  logic              cpu_gnt, dbg_gnt;
  logic              cpu_rvalid, dbg_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

`ifdef DMEM_ARB_AGING_EN
  dmem_arb_aging #(
    .MAX_WAIT (MAX_WAIT)
  ) u_aging (
    .clk       (clk),
    .rst_n     (rst_n),
    .dbg_req_i (bus.dbg_req),
    .dbg_gnt_i (dbg_gnt),
    .hit_o     (aging_hit)
  );
`else
  assign aging_hit = 1'b0;
`endif

  // Grants are held low during reset so nothing reaches the SRAM.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (bus.dbg_req && (state_q == LOCK || aging_hit)) dbg_gnt = 1'b1;
      else if (bus.cpu_req)                               cpu_gnt = 1'b1;
      else if (bus.dbg_req)                               dbg_gnt = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (dbg_gnt && bus.dbg_lock) state_d = LOCK;
      LOCK: if ((dbg_gnt && !bus.dbg_lock) || !bus.dbg_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_pend_d = (cpu_gnt && !bus.cpu_we) || (dbg_gnt && !bus.dbg_we);
    rd_own_d  = dbg_gnt ? OWN_DBG : OWN_CPU;
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and all
  // state updates use non-blocking assignments to avoid read/write races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      rd_own_q  <= OWN_CPU;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  assign mem_addr  = cpu_gnt ? bus.cpu_addr  : (dbg_gnt ? bus.dbg_addr  : '0);
  assign mem_wdata = cpu_gnt ? bus.cpu_wdata : (dbg_gnt ? bus.dbg_wdata : '0);
  assign mem_rdata = bus.mem_rdata;

  assign bus.mem_en    = cpu_gnt | dbg_gnt;
  assign bus.mem_we    = (cpu_gnt & bus.cpu_we) | (dbg_gnt & bus.dbg_we);
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.cpu_stall = rst_n & bus.cpu_req & ~cpu_gnt;

  // Response goes to whoever owned the read, even if ownership has moved on.
  assign cpu_rvalid     = rst_n & rd_pend_q & (rd_own_q == OWN_CPU);
  assign dbg_rvalid     = rst_n & rd_pend_q & (rd_own_q == OWN_DBG);
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dbg_rvalid = dbg_rvalid;
  assign bus.cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign bus.dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
endmodule
